// File: rtl/lcd_bus_scheduler.sv
// Arbiter and nibble serialiser that is the sole driver of the 4-bit LCD bus.
// Define LCD_LONG_CMD_WAIT_EN to stretch the execution wait after clear/home commands.
module lcd_bus_scheduler #(
    parameter int E_SETUP   = 2,
    parameter int E_HIGH    = 12,
    parameter int E_HOLD    = 1,
    parameter int NIB_GAP   = 50,
    parameter int CMD_WAIT  = 2000,
    parameter int LONG_WAIT = 82000,
    parameter int CNT_W     = 17
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  req,
    input  logic [23:0] req_data,
    input  logic [2:0]  req_rs,
    input  logic [2:0]  req_nib,
    output logic [2:0]  gnt,
    output logic [2:0]  done,
    output logic        busy,
    output logic        LCD_RS,
    output logic        LCD_RW,
    output logic        LCD_E,
    output logic [3:0]  SF_D
);

    typedef enum logic [3:0] {
        IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L, WAIT, DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_M1 = CNT_W'(E_SETUP - 1);
    localparam logic [CNT_W-1:0] HIGH_M1  = CNT_W'(E_HIGH - 1);
    localparam logic [CNT_W-1:0] HOLD_M1  = CNT_W'(E_HOLD - 1);
    localparam logic [CNT_W-1:0] GAP_M1   = CNT_W'(NIB_GAP - 1);
    localparam logic [CNT_W-1:0] CMD_M1   = CNT_W'(CMD_WAIT - 1);
    localparam int               MAX_WAIT = (LONG_WAIT > CMD_WAIT) ? LONG_WAIT : CMD_WAIT;

    if (E_SETUP < 1 || E_HIGH < 1 || E_HOLD < 1 || NIB_GAP < 1 || CMD_WAIT < 1 ||
        LONG_WAIT < 1 || (MAX_WAIT - 1) >= (1 << CNT_W)) begin : g_bad_params
        $error("lcd_bus_scheduler: phase lengths must be >= 1 and fit the counter");
    end

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       src_q, src_d;
    logic [7:0]       data_q, data_d;
    logic             rs_q, rs_d, nib_q, nib_d;
    logic             rr_q, rr_d;        // 0: src1 wins a src1/src2 tie, 1: src2 wins
    logic [2:0]       gnt_q, gnt_d, done_q, done_d;
    logic             busy_q, busy_d, lcd_e_q, lcd_e_d, lcd_rs_q, lcd_rs_d;
    logic [3:0]       sf_q, sf_d;
    logic [1:0]       win;
    logic [CNT_W-1:0] wait_m1;
    logic             last;

    always_comb begin
`ifdef LCD_LONG_CMD_WAIT_EN
        wait_m1 = (!rs_q && !nib_q && (data_q inside {8'h01, 8'h02, 8'h03}))
                ? CNT_W'(LONG_WAIT - 1) : CMD_M1;
`else
        wait_m1 = CMD_M1;
`endif
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        data_d  = data_q;
        rs_d    = rs_q;
        nib_d   = nib_q;
        rr_d    = rr_q;
        win     = 2'd0;
        last    = (cnt_q == '0);
        cnt_d   = last ? cnt_q : cnt_q - 1'b1;

        unique case (state_q)
            IDLE: begin
                if (req[0])                           win = 2'd0;
                else if (req[1] && (!req[2] || !rr_q)) win = 2'd1;
                else                                  win = 2'd2;
                if (|req) begin
                    src_d   = win;
                    data_d  = req_data[{win, 3'b000} +: 8];
                    rs_d    = req_rs[win];
                    nib_d   = req_nib[win];
                    state_d = req_nib[win] ? SETUP_L : SETUP_H;
                    cnt_d   = SETUP_M1;
                    if (win != 2'd0) rr_d = (win == 2'd1);
                end
            end
            SETUP_H: if (last) begin state_d = PULSE_H; cnt_d = HIGH_M1;  end
            PULSE_H: if (last) begin state_d = HOLD_H;  cnt_d = HOLD_M1;  end
            HOLD_H:  if (last) begin state_d = GAP;     cnt_d = GAP_M1;   end
            GAP:     if (last) begin state_d = SETUP_L; cnt_d = SETUP_M1; end
            SETUP_L: if (last) begin state_d = PULSE_L; cnt_d = HIGH_M1;  end
            PULSE_L: if (last) begin state_d = HOLD_L;  cnt_d = HOLD_M1;  end
            HOLD_L:  if (last) begin state_d = WAIT;    cnt_d = wait_m1;  end
            WAIT:    if (last) begin state_d = DONE;    cnt_d = '0;       end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Pin values are decoded from the next state and registered, keeping the LCD pins glitch-free.
    always_comb begin
        gnt_d    = (state_d != IDLE) ? (3'b001 << src_d) : 3'b000;
        done_d   = (state_d == DONE) ? (3'b001 << src_d) : 3'b000;
        busy_d   = (state_d != IDLE);
        lcd_e_d  = (state_d inside {PULSE_H, PULSE_L});
        lcd_rs_d = 1'b0;
        sf_d     = 4'h0;
        if (state_d inside {SETUP_H, PULSE_H, HOLD_H}) begin
            lcd_rs_d = rs_d;
            sf_d     = data_d[7:4];
        end else if (state_d inside {SETUP_L, PULSE_L, HOLD_L}) begin
            lcd_rs_d = rs_d;
            sf_d     = data_d[3:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            src_q    <= 2'd0;
            data_q   <= 8'h00;
            rs_q     <= 1'b0;
            nib_q    <= 1'b0;
            rr_q     <= 1'b0;
            gnt_q    <= 3'b000;
            done_q   <= 3'b000;
            busy_q   <= 1'b0;
            lcd_e_q  <= 1'b0;
            lcd_rs_q <= 1'b0;
            sf_q     <= 4'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            src_q    <= src_d;
            data_q   <= data_d;
            rs_q     <= rs_d;
            nib_q    <= nib_d;
            rr_q     <= rr_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
            lcd_e_q  <= lcd_e_d;
            lcd_rs_q <= lcd_rs_d;
            sf_q     <= sf_d;
        end
    end

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign busy   = busy_q;
    assign LCD_RS = lcd_rs_q;
    assign LCD_RW = 1'b0;
    assign LCD_E  = lcd_e_q;
    assign SF_D   = sf_q;

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
// Directed bench for lcd_bus_scheduler: reset, arbitration order, nibble timing and latencies.
// Each transaction is compared cycle by cycle against a timeline built from the default parameters.
module tb_lcd_bus_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req, req_rs, req_nib;
    logic [23:0] req_data;
    logic [2:0]  gnt, done;
    logic        busy, LCD_RS, LCD_RW, LCD_E;
    logic [3:0]  SF_D;

    int n_tests = 0;
    int n_fail  = 0;

`ifdef LCD_LONG_CMD_WAIT_EN
    localparam int LONG_LAT = 82080;
`else
    localparam int LONG_LAT = 2080;
`endif

    lcd_bus_scheduler dut (
        .clk(clk), .reset(reset), .req(req), .req_data(req_data), .req_rs(req_rs),
        .req_nib(req_nib), .gnt(gnt), .done(done), .busy(busy), .LCD_RS(LCD_RS),
        .LCD_RW(LCD_RW), .LCD_E(LCD_E), .SF_D(SF_D)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows one transaction from its first SETUP cycle (k=0) to done at k=lat.
    task automatic watch(input string tag, input logic [2:0] exp_g, input logic [7:0] d,
                         input logic r, input logic n, input int lat, input logic [2:0] drop,
                         input int raise_at, input logic [2:0] raise);
        int k, bad, loc;
        logic act, hi, e, rsx;
        logic [3:0] sf;
        k = 0;
        bad = 0;
        for (int i = 0; i < 200 && busy !== 1'b1; i++) @(negedge clk);
        check({tag, "_start"}, {31'd0, busy}, 32'd1);
        while (k < lat + 20 && done === 3'b000) begin
            act = 1'b0; hi = 1'b0; loc = 0;
            if (n) begin
                if (k < 15) begin act = 1'b1; loc = k; end
            end else if (k < 15) begin
                act = 1'b1; hi = 1'b1; loc = k;
            end else if (k >= 65 && k < 80) begin
                act = 1'b1; loc = k - 65;
            end
            e   = act && loc >= 2 && loc < 14;
            rsx = act & r;
            sf  = !act ? 4'h0 : (hi ? d[7:4] : d[3:0]);
            if (LCD_E !== e || LCD_RS !== rsx || SF_D !== sf || LCD_RW !== 1'b0 ||
                gnt !== exp_g || busy !== 1'b1) bad++;
            if (k == raise_at) req = req | raise;
            k++;
            @(negedge clk);
        end
        check({tag, "_latency"}, k, lat);
        check({tag, "_wave"}, bad, 0);
        check({tag, "_done"}, {20'd0, gnt, done, LCD_E, LCD_RS, SF_D}, {20'd0, exp_g, exp_g, 6'd0});
        req = req & ~drop;
        @(negedge clk);
        check({tag, "_idle"}, {19'd0, busy, gnt, done, LCD_E, LCD_RS, SF_D}, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        req      = 3'b111;
        req_data = {8'h41, 8'h28, 8'hA5};
        req_rs   = 3'b000;
        req_nib  = 3'b000;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", {19'd0, gnt, done, busy, LCD_RS, LCD_RW, LCD_E, SF_D}, 32'd0);
        end

        // Abort a src0 transfer in PULSE_H.
        req   = 3'b001;
        reset = 1'b1;
        for (int i = 0; i < 100 && LCD_E !== 1'b1; i++) @(negedge clk);
        check("reach_pulse_h", {31'd0, LCD_E}, 32'd1);
        check("pulse_h_nibble", {28'd0, SF_D}, 32'hA);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        req   = 3'b000;
        @(negedge clk);
        check("abort_outputs", {19'd0, gnt, done, busy, LCD_RS, LCD_RW, LCD_E, SF_D}, 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", {28'd0, busy, done}, 32'd0);
        end

        // All three held: src0 nibble, then src1/src2 alternate (src2 carries data with rs=1).
        req_data = {8'h41, 8'h28, 8'h03};
        req_rs   = 3'b100;
        req_nib  = 3'b001;
        req      = 3'b111;
        watch("arb0_src0_nib", 3'b001, 8'h03, 1'b0, 1'b1, 2015, 3'b001, -1, 3'b000);
        watch("arb1_src1",     3'b010, 8'h28, 1'b0, 1'b0, 2080, 3'b000, -1, 3'b000);
        watch("arb2_src2_rs",  3'b100, 8'h41, 1'b1, 1'b0, 2080, 3'b000, -1, 3'b000);
        watch("arb3_src1",     3'b010, 8'h28, 1'b0, 1'b0, 2080, 3'b000, -1, 3'b000);
        watch("arb4_src2",     3'b100, 8'h41, 1'b1, 1'b0, 2080, 3'b110, -1, 3'b000);

        // src0 arrives during a src2 transfer and waits for it.
        req = 3'b100;
        watch("noprmt_src2", 3'b100, 8'h41, 1'b1, 1'b0, 2080, 3'b100, 100, 3'b001);
        watch("noprmt_src0", 3'b001, 8'h03, 1'b0, 1'b1, 2015, 3'b001, -1, 3'b000);

        // Clear-display command from src1.
        req_data[15:8] = 8'h01;
        req = 3'b010;
        watch("long_cmd", 3'b010, 8'h01, 1'b0, 1'b0, LONG_LAT, 3'b010, -1, 3'b000);

        repeat (3) @(negedge clk);
        check("final_idle", {28'd0, busy, gnt}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/lcd_bus_scheduler.md
Name: lcd_bus_scheduler

Overview:
- Arbitrates the single 4-bit LCD bus (LCD_RS, LCD_RW, LCD_E, SF_D[11:8]) between three command sources.
  - Source 0: power-on initialisation sequencer.
  - Source 1: configuration/command sequencer.
  - Source 2: character-data streamer.
- Serialises each granted byte into upper/lower nibble writes with correct E-pulse setup, high and hold timing, then enforces the post-command execution wait.
- Replaces the per-source E/nibble timing currently spread across the sequencers; it is the only driver of the LCD pins.

Parameters:
- E_SETUP, 2, cycles RS/SF_D are stable before LCD_E rises (≥40 ns at 50 MHz).
- E_HIGH, 12, cycles LCD_E is held high (≥230 ns).
- E_HOLD, 1, cycles RS/SF_D are held after LCD_E falls.
- NIB_GAP, 50, idle cycles between upper and lower nibble (1 µs).
- CMD_WAIT, 2000, execution wait after the last nibble (40 µs).
- LONG_WAIT, 82000, execution wait for clear/home commands (1.64 ms); used only with the optional feature.
- CNT_W, 17, width of the shared timing counter; must hold max(LONG_WAIT, CMD_WAIT) − 1.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  synchronous, active-low reset
- req  in  3  per-source request; level, held until that source's done
- req_data  in  24  byte per source; [7:0]=src0, [15:8]=src1, [23:16]=src2
- req_rs  in  3  RS value per source (0 = command, 1 = data)
- req_nib  in  3  1 = single-nibble transfer (sends req_data[3:0] of that source only)
- gnt  out  3  one-hot grant, high for the whole transaction
- done  out  3  one-cycle completion pulse to the granted source
- busy  out  1  high whenever state ≠ IDLE
- LCD_RS  out  1  register select to the LCD
- LCD_RW  out  1  tied 0 (write only)
- LCD_E  out  1  enable strobe
- SF_D  out  4  [11:8] LCD data nibble

Behaviour:
- Reset (reset=0 at a clk edge):
  - State returns to IDLE.
  - gnt, done, busy, LCD_RS, LCD_RW, LCD_E and SF_D all go to 0.
  - The round-robin pointer is set to favour src1.
  - A transfer in progress is abandoned with no done pulse.
- States: IDLE, SETUP_H, PULSE_H, HOLD_H, GAP, SETUP_L, PULSE_L, HOLD_L, WAIT, DONE.
- Arbitration, evaluated only in IDLE:
  - src0 has absolute priority.
  - src1 and src2 alternate round-robin; the pointer flips to the other source after each src1/src2 grant.
- Capture and grant:
  - In IDLE with any eligible req, the winner's data, rs and nib are captured on the next edge.
  - On the same edge gnt goes one-hot and the FSM enters SETUP_H, or SETUP_L if nib=1.
  - The captured values are used for the rest of the transaction; later changes on req_* are ignored.
- Nibble phases:
  - SETUP_x lasts E_SETUP cycles, PULSE_x lasts E_HIGH cycles, HOLD_x lasts E_HOLD cycles.
  - LCD_E=1 only in PULSE_x.
  - SF_D = data[7:4] in the *_H states and data[3:0] in the *_L states; SF_D=0 in all other states.
  - LCD_RS = captured rs from SETUP through HOLD; LCD_RS=0 in all other states.
- Sequencing:
  - HOLD_H → GAP for NIB_GAP cycles → SETUP_L.
  - HOLD_L → WAIT for CMD_WAIT cycles → DONE for 1 cycle.
- DONE: done[k]=1 for the granted source; gnt clears on the following edge; FSM returns to IDLE.
  - Minimum one IDLE cycle between transactions.
- Latency, with T = first SETUP cycle and done high at T+L:
  - Full byte: L = 2·(E_SETUP+E_HIGH+E_HOLD)+NIB_GAP+CMD_WAIT, which is 2080 with defaults.
  - Nibble-only: L = E_SETUP+E_HIGH+E_HOLD+CMD_WAIT, which is 2015.
- Counter:
  - A single CNT_W-bit down-counter is loaded with (phase length − 1) on each phase entry.
  - The phase advances when the counter is 0.
  - A phase length of 0 is illegal; every parameter must be ≥1.
- Simultaneous and boundary cases:
  - A req dropped before grant is simply not served.
  - A req still asserted by the same source in the cycle after done is treated as a new request.
  - All three requesting at once are served in the order src0, then the round-robin winner, then the other.
  - A src0 request arriving mid-transaction waits; there is no preemption.

Optional Feature:
- Macro LCD_LONG_CMD_WAIT_EN.
- When defined, WAIT uses LONG_WAIT instead of CMD_WAIT if all three hold:
  - captured rs=0,
  - nib=0,
  - captured data is 8'h01 (clear) or 8'h02/8'h03 (home).
- When undefined, CMD_WAIT is always used and the LONG_WAIT parameter is unused.

Test Plan:
- Reset hold / mid-transfer:
  - Stimulus: hold reset=0 for 3 cycles with req=3'b111.
  - Required: all outputs stay 0, busy=0.
  - Stimulus: release reset, then assert it in the PULSE_H state.
  - Required: LCD_E falls next cycle, FSM in IDLE, no done pulse.
- Single byte:
  - Stimulus: src1 sends 8'h28 with rs=0.
  - Required: SF_D=4'h2 with LCD_E high for exactly 12 cycles; SF_D=4'h8 after a 50-cycle gap; done[1] at T+2080; LCD_RW=0 throughout.
- Nibble-only:
  - Stimulus: src0 sends req_data[3:0]=4'h3 with nib=1.
  - Required: one E pulse with SF_D=4'h3; done[0] at T+2015.
- Arbitration:
  - Stimulus: req=3'b111 held through all transactions.
  - Required grant order: src0, src1, src2, src1, src2, ...
  - Stimulus: src0 raises req during a src2 transfer.
  - Required: the src2 transfer finishes first, then src0 is granted next.
- Data RS:
  - Stimulus: src2 sends 8'h41 with rs=1.
  - Required: LCD_RS=1 through both nibbles and 0 during GAP, WAIT and IDLE.
- Long command:
  - Stimulus: src1 sends 8'h01 with rs=0.
  - Required: done at T+82080 with LCD_LONG_CMD_WAIT_EN defined; T+2080 without it.
